// File: rtl/nmt_ex_stage.sv
// Execute stage of the NMT multithreaded pipeline with its EX/MEM register.
// Optional macro EX_MUL_EN enables opcode 8 as a 32-bit unsigned multiply (low word).
module nmt_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          control_cmd,
    input  logic [AW-1:0] address,
    input  logic [AW-1:0] freed_address,
    input  logic [DW-1:0] opcode,
    input  logic [DW-1:0] cmd_type,
    input  logic [DW-1:0] reg1,
    input  logic [DW-1:0] reg2,
    input  logic [DW-1:0] imm_alu,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] pc_i,
    input  logic [DW-1:0] instr,
    input  logic [DW-1:0] reg_dst,
    output logic          context_switch,
    output logic [DW-1:0] thread_address,
    output logic [DW-1:0] ALU_output,
    output logic [DW-1:0] opcode_o,
    output logic          cond,
    output logic [DW-1:0] instr_o,
    output logic [DW-1:0] reg2_o,
    output logic          mem_write,
    output logic          alu_write,
    output logic [DW-1:0] cmd_type_o,
    output logic [DW-1:0] reg_dst_o
);

    localparam logic [2:0] CMD_R      = 3'd0;
    localparam logic [2:0] CMD_I      = 3'd1;
    localparam logic [2:0] CMD_LOAD   = 3'd2;
    localparam logic [2:0] CMD_STORE  = 3'd3;
    localparam logic [2:0] CMD_BRANCH = 3'd4;

    logic [2:0]    cls;
    logic [DW-1:0] op_b;
    logic [DW-1:0] eff_addr;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] result_d;
    logic          cond_d;
    logic          alu_write_d;
    logic          mem_write_d;
    logic          is_mem;

    logic [DW-1:0] result_q, opcode_q, instr_q, reg2_q, cmd_type_q, reg_dst_q;
    logic          cond_q, mem_write_q, alu_write_q;

    assign cls      = cmd_type[2:0];
    assign op_b     = (cls == CMD_I) ? imm_alu : reg2;
    assign eff_addr = reg1 + imm_alu;
    assign is_mem   = (cls == CMD_LOAD) || (cls == CMD_STORE);

    always_comb begin
        alu_res = '0;
        case (opcode[3:0])
            4'd0: alu_res = reg1 + op_b;
            4'd1: alu_res = reg1 - op_b;
            4'd2: alu_res = reg1 & op_b;
            4'd3: alu_res = reg1 | op_b;
            4'd4: alu_res = reg1 ^ op_b;
            4'd5: alu_res = reg1 << op_b[4:0];
            4'd6: alu_res = reg1 >> op_b[4:0];
            4'd7: alu_res = {{(DW-1){1'b0}}, ($signed(reg1) < $signed(op_b))};
`ifdef EX_MUL_EN
            4'd8: alu_res = reg1 * op_b;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        result_d    = '0;
        cond_d      = 1'b0;
        alu_write_d = 1'b0;
        mem_write_d = 1'b0;
        case (cls)
            CMD_R, CMD_I: begin
                result_d    = alu_res;
                alu_write_d = 1'b1;
            end
            CMD_LOAD: begin
                result_d    = eff_addr;
                mem_write_d = 1'b1;
            end
            CMD_STORE: result_d = eff_addr;
            CMD_BRANCH: begin
                result_d = pc_i + imm;
                cond_d   = opcode[0] ? (reg1 != reg2) : (reg1 == reg2);
            end
            default: result_d = '0;
        endcase
    end

    // A freed address wins over a simultaneous use of the same address.
    assign context_switch = is_mem
                         && (eff_addr[AW-1:0] == address)
                         && (eff_addr[AW-1:0] != freed_address)
                         && ((cls == CMD_STORE) || control_cmd);

    assign thread_address = {{(DW-8){1'b0}}, eff_addr[7:0]};

    always_ff @(posedge clk) begin
        if (!rst_n || context_switch) begin
            result_q    <= '0;
            opcode_q    <= '0;
            instr_q     <= '0;
            reg2_q      <= '0;
            cmd_type_q  <= '0;
            reg_dst_q   <= '0;
            cond_q      <= 1'b0;
            mem_write_q <= 1'b0;
            alu_write_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            opcode_q    <= opcode;
            instr_q     <= instr;
            reg2_q      <= reg2;
            cmd_type_q  <= cmd_type;
            reg_dst_q   <= reg_dst;
            cond_q      <= cond_d;
            mem_write_q <= mem_write_d;
            alu_write_q <= alu_write_d;
        end
    end

    assign ALU_output = result_q;
    assign opcode_o   = opcode_q;
    assign instr_o    = instr_q;
    assign reg2_o     = reg2_q;
    assign cmd_type_o = cmd_type_q;
    assign reg_dst_o  = reg_dst_q;
    assign cond       = cond_q;
    assign mem_write  = mem_write_q;
    assign alu_write  = alu_write_q;

endmodule

// File: tb/tb_nmt_ex_stage.sv
// Table-driven self-checking bench for nmt_ex_stage, plus reset sequences.
module tb_nmt_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        control_cmd;
    logic [8:0]  address, freed_address;
    logic [31:0] opcode, cmd_type, reg1, reg2, imm_alu, imm, pc_i, instr, reg_dst;
    logic        context_switch;
    logic [31:0] thread_address, ALU_output, opcode_o, instr_o, reg2_o, cmd_type_o, reg_dst_o;
    logic        cond, mem_write, alu_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nmt_ex_stage #(.DW(32), .AW(9)) dut (
        .clk(clk), .rst_n(rst_n), .control_cmd(control_cmd),
        .address(address), .freed_address(freed_address),
        .opcode(opcode), .cmd_type(cmd_type), .reg1(reg1), .reg2(reg2),
        .imm_alu(imm_alu), .imm(imm), .pc_i(pc_i), .instr(instr), .reg_dst(reg_dst),
        .context_switch(context_switch), .thread_address(thread_address),
        .ALU_output(ALU_output), .opcode_o(opcode_o), .cond(cond), .instr_o(instr_o),
        .reg2_o(reg2_o), .mem_write(mem_write), .alu_write(alu_write),
        .cmd_type_o(cmd_type_o), .reg_dst_o(reg_dst_o)
    );

    typedef struct {
        string       name;
        logic [31:0] cmd, op, r1, r2, imma, immb, pc;
        logic [8:0]  addr, freed;
        logic        ccmd;
        logic        exp_cs;
        logic [31:0] exp_ta;
        logic        chk_alu;
        logic [31:0] exp_alu;
        logic        exp_cond, exp_mw, exp_aw;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] cmd, input logic [31:0] op,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imma,
                                input logic [31:0] immb, input logic [31:0] pc, input logic [8:0] addr,
                                input logic [8:0] freed, input logic ccmd, input logic exp_cs,
                                input logic [31:0] exp_ta, input logic chk_alu, input logic [31:0] exp_alu,
                                input logic exp_cond, input logic exp_mw, input logic exp_aw);
        vec_t v;
        v.name = name; v.cmd = cmd; v.op = op; v.r1 = r1; v.r2 = r2; v.imma = imma;
        v.immb = immb; v.pc = pc; v.addr = addr; v.freed = freed; v.ccmd = ccmd;
        v.exp_cs = exp_cs; v.exp_ta = exp_ta; v.chk_alu = chk_alu; v.exp_alu = exp_alu;
        v.exp_cond = exp_cond; v.exp_mw = exp_mw; v.exp_aw = exp_aw;
        return v;
    endfunction

    task automatic drive(input vec_t v, input int idx);
        cmd_type = v.cmd; opcode = v.op; reg1 = v.r1; reg2 = v.r2;
        imm_alu = v.imma; imm = v.immb; pc_i = v.pc;
        address = v.addr; freed_address = v.freed; control_cmd = v.ccmd;
        instr = 32'hA000_0000 + 32'(idx);
        reg_dst = 32'(idx + 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".ALU_output"}, ALU_output, 32'd0);
        chk({tag, ".opcode_o"},   opcode_o,   32'd0);
        chk({tag, ".instr_o"},    instr_o,    32'd0);
        chk({tag, ".reg2_o"},     reg2_o,     32'd0);
        chk({tag, ".cmd_type_o"}, cmd_type_o, 32'd0);
        chk({tag, ".reg_dst_o"},  reg_dst_o,  32'd0);
        chk({tag, ".ctrl"}, {29'd0, cond, mem_write, alu_write}, 32'd0);
    endtask

    logic [31:0] mul_exp;

    initial begin
`ifdef EX_MUL_EN
        mul_exp = 32'd6;
`else
        mul_exp = 32'd0;
`endif
        //            name        cmd op  r1            r2            imma         imm  pc    addr   freed  cc cs ta     ck alu            cd mw aw
        vecs.push_back(mk("r_add",   0, 0, 32'd5,        32'd7,        32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h05, 1, 32'd12,        0, 0, 1));
        vecs.push_back(mk("r_sub",   0, 1, 32'd5,        32'd7,        32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h05, 1, 32'hFFFFFFFE,  0, 0, 1));
        vecs.push_back(mk("i_slt",   1, 7, 32'hFFFFFFFF, 32'h80000000, 32'd1,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h00, 1, 32'd1,         0, 0, 1));
        vecs.push_back(mk("br_ne",   4, 1, 32'd3,        32'd4,        32'd0,       8,   32'h40,9'h1ff,9'h0, 0, 0, 32'h03, 1, 32'h48,        1, 0, 0));
        vecs.push_back(mk("br_eq_t", 4, 0, 32'd3,        32'd3,        32'd0,       8,   32'h40,9'h1ff,9'h0, 0, 0, 32'h03, 1, 32'h48,        1, 0, 0));
        vecs.push_back(mk("br_eq_f", 4, 2, 32'd3,        32'd4,        32'd0,       32'hFFFFFFF0, 32'h40,9'h1ff,9'h0, 0, 0, 32'h03, 1, 32'h30, 0, 0, 0));
        vecs.push_back(mk("r_and",   0, 2, 32'hF0F0,     32'hFF00,     32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'hF0, 1, 32'hF000,      0, 0, 1));
        vecs.push_back(mk("r_or",    0, 3, 32'hF0F0,     32'hFF00,     32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'hF0, 1, 32'hFFF0,      0, 0, 1));
        vecs.push_back(mk("r_xor",   0, 4, 32'hF0F0,     32'hFF00,     32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'hF0, 1, 32'h0FF0,      0, 0, 1));
        vecs.push_back(mk("i_sll",   1, 5, 32'd1,        32'd0,        32'h24,      0,   0,    9'h1ff,9'h0, 0, 0, 32'h25, 1, 32'h10,        0, 0, 1));
        vecs.push_back(mk("r_srl",   0, 6, 32'h80000000, 32'd31,       32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h00, 1, 32'd1,         0, 0, 1));
        vecs.push_back(mk("r_slt_f", 0, 7, 32'd7,        32'd5,        32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h07, 1, 32'd0,         0, 0, 1));
        vecs.push_back(mk("r_ovf",   0, 0, 32'hFFFFFFFF, 32'd2,        32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'hFF, 1, 32'd1,         0, 0, 1));
        vecs.push_back(mk("r_op9",   0, 9, 32'd2,        32'd3,        32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h02, 1, 32'd0,         0, 0, 1));
        vecs.push_back(mk("r_op8",   0, 8, 32'd2,        32'd3,        32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h02, 1, mul_exp,       0, 0, 1));
        vecs.push_back(mk("add_eq",  0, 0, 32'd4,        32'd4,        32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h04, 1, 32'd8,         0, 0, 1));
        vecs.push_back(mk("nop",     5, 0, 32'd4,        32'd4,        32'd0,       0,   0,    9'h1ff,9'h0, 0, 0, 32'h04, 0, 32'd0,         0, 0, 0));
        vecs.push_back(mk("st_col",  3, 0, 32'h10,       32'h99,       32'h05,      0,   0,    9'h15, 9'h0, 0, 1, 32'h15, 1, 32'd0,         0, 0, 0));
        vecs.push_back(mk("st_freed",3, 0, 32'h10,       32'h99,       32'h05,      0,   0,    9'h15, 9'h15,0, 0, 32'h15, 1, 32'h15,        0, 0, 0));
        vecs.push_back(mk("ld_hrd",  2, 0, 32'h10,       32'h0,        32'h05,      0,   0,    9'h15, 9'h0, 0, 0, 32'h15, 1, 32'h15,        0, 1, 0));
        vecs.push_back(mk("ld_hwr",  2, 0, 32'h10,       32'h0,        32'h05,      0,   0,    9'h15, 9'h0, 1, 1, 32'h15, 1, 32'd0,         0, 0, 0));
        vecs.push_back(mk("st_miss", 3, 0, 32'h10,       32'h0,        32'h05,      0,   0,    9'h16, 9'h0, 1, 0, 32'h15, 1, 32'h15,        0, 0, 0));
        vecs.push_back(mk("st_bit8", 3, 0, 32'h110,      32'h0,        32'h05,      0,   0,    9'h115,9'h0, 0, 1, 32'h15, 1, 32'd0,         0, 0, 0));
        vecs.push_back(mk("st_b8mis",3, 0, 32'h110,      32'h0,        32'h05,      0,   0,    9'h015,9'h0, 0, 0, 32'h15, 1, 32'h115,       0, 0, 0));
        vecs.push_back(mk("st_hiwr", 3, 0, 32'h310,      32'h0,        32'h05,      0,   0,    9'h115,9'h0, 0, 1, 32'h15, 1, 32'd0,         0, 0, 0));

        // Reset held for two cycles while a live instruction is presented.
        rst_n = 1'b0;
        drive(vecs[0], 0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        $display("reset: outputs checked");

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v, i);
            #1;
            chk({v.name, ".context_switch"}, {31'd0, context_switch}, {31'd0, v.exp_cs});
            chk({v.name, ".thread_address"}, thread_address, v.exp_ta);
            @(posedge clk);
            #1;
            if (v.chk_alu) chk({v.name, ".ALU_output"}, ALU_output, v.exp_alu);
            chk({v.name, ".cond"},      {31'd0, cond},      {31'd0, v.exp_cond});
            chk({v.name, ".mem_write"}, {31'd0, mem_write}, {31'd0, v.exp_mw});
            chk({v.name, ".alu_write"}, {31'd0, alu_write}, {31'd0, v.exp_aw});
            chk({v.name, ".cmd_type_o"}, cmd_type_o, v.exp_cs ? 32'd0 : v.cmd);
            chk({v.name, ".opcode_o"},   opcode_o,   v.exp_cs ? 32'd0 : v.op);
            chk({v.name, ".reg2_o"},     reg2_o,     v.exp_cs ? 32'd0 : v.r2);
            chk({v.name, ".instr_o"},    instr_o,    v.exp_cs ? 32'd0 : 32'hA000_0000 + 32'(i));
            chk({v.name, ".reg_dst_o"},  reg_dst_o,  v.exp_cs ? 32'd0 : 32'(i + 1));
            $display("vec %0d %s: cs=%0b alu=0x%08h cond=%0b mw=%0b aw=%0b ctype=%0d",
                     i, v.name, v.exp_cs, ALU_output, cond, mem_write, alu_write, cmd_type_o);
            @(negedge clk);
        end

        // Reset has priority over a valid capture of a filled register.
        drive(vecs[0], 0);
        @(posedge clk);
        #1;
        chk("pre_rst.ALU_output", ALU_output, 32'd12);
        @(negedge clk);
        rst_n = 1'b0;
        drive(vecs[1], 1);
        @(posedge clk);
        #1;
        check_all_zero("rst_prio");
        $display("rst_prio: outputs checked");

        // Combinational collision outputs ignore reset.
        @(negedge clk);
        drive(vecs[17], 17);
        #1;
        chk("rst_cs.context_switch", {31'd0, context_switch}, 32'd1);
        chk("rst_cs.thread_address", thread_address, 32'h15);
        $display("rst_cs: combinational outputs checked under reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmt_ex_stage.md
Name: nmt_ex_stage

Overview:
- Execute stage of the NMT multithreaded pipeline, with its EX/MEM pipeline register.
- Takes decoded operands from the ID/EX mux and computes the ALU result, branch condition and write-back controls.
- Detects thread/host memory-address collisions and raises context_switch.
- Drives the registered EX/MEM outputs consumed by the MEM stage and the EX/MEM MPR.

Parameters:
- DW, 32, datapath width (all operand, result and pass-through buses).
- AW, 9, host/controller memory address width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- control_cmd  in  1  host access type: 1 = host write, 0 = host read.
- address  in  AW  address currently used by the memory controller.
- freed_address  in  AW  address just released by the controller.
- opcode  in  DW  ALU function; bits [3:0] used.
- cmd_type  in  DW  instruction class; bits [2:0] used.
- reg1, reg2  in  DW  source register values.
- imm_alu  in  DW  ALU immediate (I-type second operand).
- imm  in  DW  branch offset.
- pc_i  in  DW  instruction PC.
- instr  in  DW  raw instruction.
- reg_dst  in  DW  destination register index.
- context_switch  out  1  combinational collision flag.
- thread_address  out  DW  combinational {24'b0, effective address[7:0]}.
- ALU_output, opcode_o, cond, instr_o, reg2_o, mem_write, alu_write, cmd_type_o, reg_dst_o  out  DW/1  registered EX/MEM outputs; cond, mem_write and alu_write are 1 bit.

Behaviour:
- cmd_type encoding: 0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH; 5-7 are NOP.
- ALU operand B is reg2 for R-type and imm_alu for I-type.
- ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL (shift amount B[4:0]), 6 SRL (logical), 7 SLT (signed, result 1/0). Opcodes 8-15 give 0.
- All arithmetic is modulo 2^32; overflow is ignored.
- LOAD/STORE: result = reg1 + imm_alu, the effective address.
- BRANCH: result = pc_i + imm. cond = (reg1 == reg2) when opcode[0] = 0, and (reg1 != reg2) when opcode[0] = 1. cond = 0 for every non-branch instruction.
- Write-back controls: alu_write = 1 for R/I-ALU only; mem_write = 1 for LOAD only; both 0 otherwise.
- Collision: context_switch = 1 when all of the following hold:
  - the instruction is LOAD or STORE;
  - effective address[8:0] == address;
  - effective address[8:0] != freed_address;
  - it is a STORE (any host access), or a LOAD while control_cmd = 1.
- Simultaneous use and free of the same address: freed wins, so no collision.
- EX/MEM register:
  - Each cycle it captures the result and controls, plus opcode, instr, reg2, cmd_type and reg_dst passed through. Latency is 1 cycle.
  - When context_switch = 1, it loads a bubble instead: all outputs 0 (cmd_type_o = 0, alu_write = 0, mem_write = 0). The stalled instruction is held by the external MPR.
- Reset: rst_n = 0 at a clock edge clears every registered output to 0. Reset has priority over capture.
- Reset does not affect the combinational outputs context_switch and thread_address.

Optional Feature:
- EX_MUL_EN defined: opcode 8 = MUL, the low 32 bits of the unsigned A*B product, combinational and single-cycle.
- Not defined: opcode 8 yields 0, like the other unused opcodes.

Test Plan:
- Reset: rst_n = 0 for 2 cycles -> all EX/MEM outputs 0.
- R-ADD: cmd_type = 0, opcode = 0, reg1 = 5, reg2 = 7 -> after 1 edge, ALU_output = 12, alu_write = 1, mem_write = 0. Repeat with SUB 5-7 -> 0xFFFFFFFE.
- I-SLT: cmd_type = 1, opcode = 7, reg1 = 0xFFFFFFFF, imm_alu = 1 -> ALU_output = 1.
- BRANCH: cmd_type = 4, opcode = 1, reg1 = 3, reg2 = 4, pc_i = 0x40, imm = 8 -> cond = 1, ALU_output = 0x48.
- Collision:
  - STORE, reg1 = 0x10, imm_alu = 0x05, address = 0x15, freed_address = 0 -> context_switch = 1 and thread_address = 0x15; next edge all outputs 0.
  - Same with freed_address = 0x15 -> context_switch = 0 and the store is captured with cmd_type_o = 3.
- LOAD collision polarity: LOAD at effective address 0x15 with address = 0x15:
  - control_cmd = 0 -> context_switch = 0 and mem_write = 1 after the edge.
  - control_cmd = 1 -> context_switch = 1.
